// File: rtl/out_port_pkg.sv
// Shared constants for the core's output-port write path.
// Status byte layout and default bus addresses live here.
package out_port_pkg;

    localparam logic [7:0] OUT_ADDR_DEF    = 8'hFF;
    localparam logic [7:0] STATUS_ADDR_DEF = 8'hFE;

    localparam int ST_OVF    = 7;
    localparam int ST_FULL   = 6;
    localparam int ST_EMPTY  = 5;
    localparam int ST_OCC_HI = 4;
    localparam int ST_OCC_LO = 0;

    // Assemble the status byte from the individual FIFO flags.
    function automatic logic [7:0] pack_status(
        input logic       ovf,
        input logic       full,
        input logic       empty,
        input logic [4:0] occ
    );
        logic [7:0] s;
        s = '0;
        s[ST_OVF]              = ovf;
        s[ST_FULL]             = full;
        s[ST_EMPTY]            = empty;
        s[ST_OCC_HI:ST_OCC_LO] = occ;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide show-ahead FIFO with registered full/empty flags.
// Pointers wrap naturally; occupancy is a separate 5-bit counter.
module sync_fifo
    import out_port_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic [4:0] occ
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    occ_q, occ_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    // Next-state for storage, pointers, occupancy and flags.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        occ_d   = occ_q + {4'b0, push} - {4'b0, pop};
        full_d  = (occ_d == 5'(DEPTH));
        empty_d = (occ_d == 5'd0);
    end

    // State register; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign occ   = occ_q;

endmodule

// File: rtl/out_port_fifo.sv
// Output-port receiver: decodes core byte writes into a drain FIFO.
// Define OUT_STATUS_EN to build the readable status register.
module out_port_fifo
    import out_port_pkg::*;
#(
    parameter int         DEPTH       = 8,
    parameter logic [7:0] OUT_ADDR    = OUT_ADDR_DEF,
    parameter logic [7:0] STATUS_ADDR = STATUS_ADDR_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] adr,
    input  logic [7:0] writedata,
    input  logic       memWr,
    input  logic       memRd,
    output logic [7:0] rdata,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       full,
    output logic       empty,
    output logic       ovf,
    output logic [5:0] count
);

    logic       wr_hit;
    logic       push;
    logic       pop;
    logic [4:0] occ;
    logic       ovf_q, ovf_d;
    logic [5:0] count_q, count_d;

    sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (writedata),
        .head  (out_data),
        .full  (full),
        .empty (empty),
        .occ   (occ)
    );

    // A write while full is still accepted if the head leaves this cycle.
    always_comb begin
        wr_hit = memWr && (adr == OUT_ADDR);
        pop    = !empty && out_ready;
        push   = wr_hit && (!full || pop);
    end

    // Sticky overflow and wrapping count of accepted bytes.
    always_comb begin
        ovf_d   = ovf_q | (wr_hit && !push);
        count_d = count_q + {5'b0, push};
    end

    // Overflow and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

`ifdef OUT_STATUS_EN
    logic       st_hit;
    logic [7:0] rdata_q, rdata_d;

    // Snapshot the flags on a status read; hold otherwise.
    always_comb begin
        st_hit  = memRd && (adr == STATUS_ADDR);
        rdata_d = rdata_q;
        if (st_hit) begin
            rdata_d = pack_status(ovf_q, full, empty, occ);
        end
    end

    // Status read-data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, memRd, STATUS_ADDR, occ};
    assign rdata     = 8'h00;
`endif

    assign out_valid = !empty;
    assign ovf       = ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo: directed table,
// hand-written corner sequences and a randomized queue model.
module tb_out_port_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] adr;
    logic [7:0] writedata;
    logic       memWr;
    logic       memRd;
    logic [7:0] rdata;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       full;
    logic       empty;
    logic       ovf;
    logic [5:0] count;

    always #5 clk = ~clk;

    out_port_fifo #(
        .DEPTH       (DEPTH),
        .OUT_ADDR    (8'hFF),
        .STATUS_ADDR (8'hFE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memWr     (memWr),
        .memRd     (memRd),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .count     (count)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of bytes plus flags.
    logic [7:0] q[$];
    logic       m_ovf;
    int         m_count;
    logic [7:0] m_rdata;

    typedef struct {
        logic       wr;
        logic [7:0] adr;
        logic [7:0] wd;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        logic [5:0] e_count;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_count = 0;
        m_rdata = 8'h00;
    endtask

    task automatic model_edge();
        int   n;
        logic hit;
        logic pp;
        logic ps;
        n   = q.size();
        hit = memWr && (adr == 8'hFF);
        pp  = (n > 0) && out_ready;
        ps  = hit && ((n < DEPTH) || pp);
`ifdef OUT_STATUS_EN
        if (memRd && adr == 8'hFE)
            m_rdata = {m_ovf, n == DEPTH, n == 0, 5'(n)};
`endif
        if (pp) void'(q.pop_front());
        if (ps) q.push_back(writedata);
        if (hit && !ps) m_ovf = 1'b1;
        if (ps) m_count = (m_count + 1) % 64;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memWr     = 1'b0;
        memRd     = 1'b0;
        adr       = 8'h00;
        writedata = 8'h00;
        out_ready = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d,
                      input logic rdy);
        memWr     = 1'b1;
        memRd     = 1'b0;
        adr       = a;
        writedata = d;
        out_ready = rdy;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, out_valid, q.size() > 0);
        if (q.size() > 0) chk({tag, ".data"}, out_data, q[0]);
        chk({tag, ".full"}, full, q.size() == DEPTH);
        chk({tag, ".empty"}, empty, q.size() == 0);
        chk({tag, ".ovf"}, ovf, m_ovf);
        chk({tag, ".count"}, count, m_count);
        chk({tag, ".rdata"}, rdata, m_rdata);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".valid"}, out_valid, 0);
        chk({tag, ".data"}, out_data, 0);
        chk({tag, ".full"}, full, 0);
        chk({tag, ".empty"}, empty, 1);
        chk({tag, ".ovf"}, ovf, 0);
        chk({tag, ".count"}, count, 0);
        chk({tag, ".rdata"}, rdata, 0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Directed vectors: write/pop, fill, overflow, drain.
        tbl[0] = '{1, 8'hFF, 8'h5A, 0, 1, 8'h5A, 0, 0, 0, 6'd1};
        tbl[1] = '{0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 1, 0, 6'd1};
        for (int i = 1; i <= 8; i++)
            tbl[1 + i] = '{1, 8'hFF, 8'(i), 0, 1, 8'h01,
                           i == 8, 0, 0, 6'(1 + i)};
        tbl[10] = '{1, 8'hFF, 8'h99, 0, 1, 8'h01, 1, 0, 1, 6'd9};
        for (int k = 1; k <= 8; k++)
            tbl[10 + k] = '{0, 8'h00, 8'h00, 1, k < 8, 8'(k + 1),
                            0, k == 8, 1, 6'd9};

        idle();
        model_reset();
        reset = 1'b0;
        #12;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            memWr     = tbl[i].wr;
            memRd     = 1'b0;
            adr       = tbl[i].adr;
            writedata = tbl[i].wd;
            out_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d.valid", i), out_valid, tbl[i].e_valid);
            if (tbl[i].e_valid)
                chk($sformatf("tbl%0d.data", i), out_data, tbl[i].e_data);
            chk($sformatf("tbl%0d.full", i), full, tbl[i].e_full);
            chk($sformatf("tbl%0d.empty", i), empty, tbl[i].e_empty);
            chk($sformatf("tbl%0d.ovf", i), ovf, tbl[i].e_ovf);
            chk($sformatf("tbl%0d.count", i), count, tbl[i].e_count);
        end

        // Full FIFO: push and pop in the same cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr(8'hFF, 8'h10 + 8'(i), 1'b0);
            step();
        end
        wr(8'hFF, 8'hAA, 1'b1);
        step();
        chk("fullpp.full", full, 1);
        chk("fullpp.data", out_data, 8'h11);
        chk("fullpp.ovf", ovf, 0);
        chk("fullpp.count", count, 9);
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 6) chk("fullpp.tail", out_data, 8'hAA);
            check_model("drain");
        end

        // Foreign address: no side effects.
        wr(8'h10, 8'h77, 1'b0);
        step();
        chk("foreign.count", count, 9);
        chk("foreign.empty", empty, 1);

        // Count wraps after 64 accepted writes.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            wr(8'hFF, 8'(i), 1'b1);
            step();
            if (i == 62) chk("wrap.count63", count, 63);
        end
        chk("wrap.count0", count, 0);
        chk("wrap.ovf", ovf, 0);
        check_model("wrap");

        // Status register reads.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wr(8'hFF, 8'(i), 1'b0);
            step();
        end
        idle();
        memRd = 1'b1;
        adr   = 8'hFE;
        step();
`ifdef OUT_STATUS_EN
        chk("status3", rdata, 8'h03);
`else
        chk("status3", rdata, 8'h00);
`endif
        for (int i = 0; i < 6; i++) begin
            wr(8'hFF, 8'h40 + 8'(i), 1'b0);
            step();
        end
        idle();
        memRd = 1'b1;
        adr   = 8'hFE;
        step();
`ifdef OUT_STATUS_EN
        chk("status_ovf", rdata, 8'hC8);
`else
        chk("status_ovf", rdata, 8'h00);
`endif
        chk("status.ovf", ovf, 1);
        check_model("status");

        // Asynchronous reset between edges with 4 entries buffered.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr(8'hFF, 8'hC0 + 8'(i), 1'b0);
            step();
        end
        idle();
        chk("pre_arst.valid", out_valid, 1);
        #3;
        reset = 1'b0;
        #1;
        check_reset_vals("arst");
        model_reset();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_model("arst_after");

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel       = int'($urandom_range(0, 5));
            adr       = (sel < 3) ? 8'hFF :
                        (sel == 3) ? 8'hFE : 8'($urandom);
            writedata = 8'($urandom);
            memWr     = 1'($urandom_range(0, 1));
            memRd     = 1'($urandom_range(0, 1));
            if (i < 300)
                out_ready = ($urandom_range(0, 3) == 0);
            else
                out_ready = ($urandom_range(0, 3) != 0);
            step();
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
